led_cnt_ctrl: RTL
=================

# led_cnt_ctrl

Register-side controller for the LED counter partition. It is the initiator end of that block's control interface. It decodes a simple single-cycle register bus from the processor side and drives the counter's divider and write-enable. It issues interrupt-clear pulses, samples the counter's interrupt count, and converts the counter's LED-interrupt output into a sticky, maskable processor interrupt. It sits in the static region, outside the reconfigurable partition, so register state survives a partition swap.

## Interface
- DIV_RST, 12'd100, reset value of DIV register and div_o
- PULSE_LEN, 1, length in cycles of each wren_o / int_clr_o pulse (1..15)
- clk100  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- reg_wr_i  input  1  write strobe, one cycle per write
- reg_rd_i  input  1  read strobe, one cycle per read
- reg_addr_i  input  4  byte address; bits [1:0] ignored
- reg_wdata_i  input  32  write data
- reg_rdata_o  output  32  read data, valid with reg_rvalid_o
- reg_rvalid_o  output  1  one-cycle read-data valid
- div_o  output  12  divider value to counter
- wren_o  output  1  divider load pulse to counter
- int_clr_o  output  1  interrupt-count clear pulse to counter
- int_cnt_i  input  32  interrupt count from counter
- led_int_i  input  1  LED interrupt level from counter
- irq_o  output  1  processor interrupt, level, registered

## Operation
- Register map:
  - 0x0 CTRL
    - bit0 LOAD: write 1 starts a load command; reads 0.
    - bit1 CLR: write 1 starts a clear command; reads 0.
    - bit2 IRQ_EN: RW, reset 0.
  - 0x4 DIV: [11:0] RW, reset DIV_RST; [31:12] read 0.
  - 0x8 INT_CNT: RO, int_cnt_i as sampled on the read-strobe cycle.
  - 0xC STATUS
    - bit0 PEND: W1C.
    - bit1 OVF: W1C; set on an edge that arrives while PEND is already 1.
    - bit2 BUSY: RO.
    - bit3 DROP: W1C; set when a LOAD/CLR write arrives while BUSY is 1.
    - Other bits read 0.
- Command FSM states: IDLE, WREN, GAP, CLR.
  - IDLE:
    - LOAD=1: latch DIV into div_o and go to WREN.
    - CLR=1 only: go to CLR.
    - Neither: stay in IDLE.
  - WREN: wren_o=1 for PULSE_LEN cycles. Then go to GAP if CLR was also requested in the same write, else go to IDLE.
  - GAP: one cycle with all pulses low, then go to CLR.
  - CLR: int_clr_o=1 for PULSE_LEN cycles, then go to IDLE.
  - BUSY=1 in every state except IDLE.
- A CTRL write with LOAD or CLR set while BUSY: the command is discarded and DROP is set. The IRQ_EN field of that write still takes effect.
- div_o changes only on a LOAD start. A DIV write during BUSY updates the register, but div_o is unchanged until the next LOAD.
- led_int_i is registered once and edge-detected; a rising edge sets PEND.
- Same-cycle W1C of PEND and a rising edge: PEND stays 1, and OVF is not set by that edge.
- irq_o = registered (PEND & IRQ_EN).
- Unmapped addresses: writes are ignored; reads return 0 with reg_rvalid_o asserted.
- Write and read to the same address in one cycle: the read returns the pre-write value.

## Timing
- Reset values:
  - div_o = DIV_RST.
  - wren_o, int_clr_o, irq_o, reg_rvalid_o = 0.
  - reg_rdata_o = 0.
  - All STATUS bits and IRQ_EN = 0.
  - FSM in IDLE.
- Read latency: strobe at cycle N gives reg_rdata_o and reg_rvalid_o at N+1. reg_rvalid_o is high for exactly one cycle; reg_rdata_o holds its value until the next read.
- Write takes effect at N+1 (register visible to a read strobed at N+1).
- LOAD written at N:
  - div_o updated at N+1.
  - wren_o high N+1 .. N+PULSE_LEN.
  - BUSY is 1 from N+1.
- LOAD+CLR written at N (PULSE_LEN=1):
  - wren_o high at N+1.
  - GAP at N+2.
  - int_clr_o high at N+3.
  - BUSY=0 at N+4.
- CLR-only written at N: int_clr_o high N+1 .. N+PULSE_LEN.
- led_int_i rising at cycle N:
  - PEND set at N+2 (one sync register, one edge register).
  - irq_o high at N+3 if IRQ_EN=1.
- Reset asserted mid-command: wren_o and int_clr_o are low in the cycle after rst is sampled high, and the FSM returns to IDLE. No partial pulse resumes.

## Test plan
- Reset then read all four registers: CTRL=0, DIV=100, STATUS=0, INT_CNT equals the driven int_cnt_i (e.g. 0x12345678).
- Write DIV=0x3E8, then CTRL=0x1 at cycle N: div_o=0x3E8 and wren_o=1 at N+1 only, BUSY reads 1 at N+1, then 0.
- Write CTRL=0x3 at N (PULSE_LEN=1): wren_o at N+1, int_clr_o at N+3. A second CTRL=0x1 written at N+2 produces no pulse and sets DROP; STATUS reads 0x8 afterwards.
- IRQ_EN=1, pulse led_int_i twice before clearing: PEND=1, OVF=1, irq_o=1. Write STATUS=0x3: irq_o drops and STATUS reads 0.
- W1C of PEND in the same cycle that a detected rising edge would set PEND: PEND remains 1 and irq_o stays high.
- Assert rst during the WREN state with PULSE_LEN=4: wren_o is low the next cycle, div_o returns to 100, and BUSY reads 0.

Source files
------------

// File: rtl/led_cnt_ctrl_if.sv
// Single-cycle register bus between the processor side (master) and the
// LED counter controller (slave).
interface led_cnt_ctrl_if;
  logic        reg_wr_i;
  logic        reg_rd_i;
  logic [3:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_rvalid_o;

  modport master (
    output reg_wr_i, reg_rd_i, reg_addr_i, reg_wdata_i,
    input  reg_rdata_o, reg_rvalid_o
  );

  modport slave (
    input  reg_wr_i, reg_rd_i, reg_addr_i, reg_wdata_i,
    output reg_rdata_o, reg_rvalid_o
  );
endinterface

// File: rtl/led_cnt_ctrl.sv
// Register-side controller for the LED counter: register decode, divider
// load / interrupt-clear command sequencer, and sticky maskable interrupt.
module led_cnt_ctrl #(
  parameter logic [11:0] DIV_RST   = 12'd100,
  parameter int          PULSE_LEN = 1
) (
  input  logic          clk100,
  input  logic          rst,
  led_cnt_ctrl_if.slave bus,
  output logic [11:0]   div_o,
  output logic          wren_o,
  output logic          int_clr_o,
  input  logic [31:0]   int_cnt_i,
  input  logic          led_int_i,
  output logic          irq_o
);
  typedef enum logic [1:0] {IDLE, WREN, GAP, CLR} state_t;

  localparam logic [3:0] LAST = 4'(PULSE_LEN - 1);
  localparam int PEND = 0;
  localparam int OVF  = 1;
  localparam int DROP = 2;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        both_reg, both_next;
  logic [11:0] div_out_reg, div_out_next;
  logic [11:0] div_reg;
  logic        irq_en_reg;
  logic        led_sync_reg, led_prev_reg;
  logic        irq_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic [2:0]  sticky_reg, sticky_set, sticky_clr;
  logic [1:0]  word;
  logic        wr_ctrl, wr_div, wr_status, rd;
  logic        cmd_load, cmd_clr, cmd_drop, busy, rise;
  logic        unused_bits;

  assign word      = bus.reg_addr_i[3:2];
  assign wr_ctrl   = bus.reg_wr_i && (word == 2'd0);
  assign wr_div    = bus.reg_wr_i && (word == 2'd1);
  assign wr_status = bus.reg_wr_i && (word == 2'd3);
  assign rd        = bus.reg_rd_i;

  assign busy     = (state_reg != IDLE);
  assign cmd_load = wr_ctrl & bus.reg_wdata_i[0];
  assign cmd_clr  = wr_ctrl & bus.reg_wdata_i[1];
  assign cmd_drop = (cmd_load | cmd_clr) & busy;
  assign rise     = led_sync_reg & ~led_prev_reg;

  // An edge landing on the same cycle as a PEND clear re-arms PEND and is
  // not counted as an overflow.
  assign sticky_set[PEND] = rise;
  assign sticky_clr[PEND] = wr_status & bus.reg_wdata_i[0];
  assign sticky_set[OVF]  = rise & sticky_reg[PEND] & ~sticky_clr[PEND];
  assign sticky_clr[OVF]  = wr_status & bus.reg_wdata_i[1];
  assign sticky_set[DROP] = cmd_drop;
  assign sticky_clr[DROP] = wr_status & bus.reg_wdata_i[3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
      always_ff @(posedge clk100) begin
        if (rst) begin
          sticky_reg[gi] <= 1'b0;
        end else begin
          sticky_reg[gi] <= sticky_set[gi] | (sticky_reg[gi] & ~sticky_clr[gi]);
        end
      end
    end
  endgenerate

  always_comb begin
    rdata_next = 32'd0;
    case (word)
      2'd0:    rdata_next[2]    = irq_en_reg;
      2'd1:    rdata_next[11:0] = div_reg;
      2'd2:    rdata_next       = int_cnt_i;
      2'd3:    rdata_next[3:0]  = {sticky_reg[DROP], busy, sticky_reg[OVF], sticky_reg[PEND]};
      default: rdata_next       = 32'd0;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      div_reg      <= DIV_RST;
      irq_en_reg   <= 1'b0;
      led_sync_reg <= 1'b0;
      led_prev_reg <= 1'b0;
      irq_reg      <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      if (wr_div) begin
        div_reg <= bus.reg_wdata_i[11:0];
      end
      if (wr_ctrl) begin
        irq_en_reg <= bus.reg_wdata_i[2];
      end
      led_sync_reg <= led_int_i;
      led_prev_reg <= led_sync_reg;
      irq_reg      <= sticky_reg[PEND] & irq_en_reg;
      rvalid_reg   <= rd;
      if (rd) begin
        rdata_reg <= rdata_next;
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      both_reg    <= 1'b0;
      div_out_reg <= DIV_RST;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      both_reg    <= both_next;
      div_out_reg <= div_out_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    both_next    = both_reg;
    div_out_next = div_out_reg;
    wren_o       = 1'b0;
    int_clr_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_load) begin
          div_out_next = div_reg;
          both_next    = cmd_clr;
          cnt_next     = 4'd0;
          state_next   = WREN;
        end else if (cmd_clr) begin
          both_next  = 1'b0;
          cnt_next   = 4'd0;
          state_next = CLR;
        end
      end
      WREN: begin
        wren_o = 1'b1;
        if (cnt_reg == LAST) begin
          cnt_next   = 4'd0;
          state_next = both_reg ? GAP : IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      GAP: begin
        cnt_next   = 4'd0;
        state_next = CLR;
      end
      CLR: begin
        int_clr_o = 1'b1;
        if (cnt_reg == LAST) begin
          cnt_next   = 4'd0;
          both_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign div_o            = div_out_reg;
  assign irq_o            = irq_reg;
  assign bus.reg_rdata_o  = rdata_reg;
  assign bus.reg_rvalid_o = rvalid_reg;
  assign unused_bits      = ^{bus.reg_addr_i[1:0], bus.reg_wdata_i[31:12]};
endmodule
